// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2**N decoder with a prescaled auto-scan mode.
// Mode 0 loads the select index from In every enabled cycle. Mode 1 advances the
// index once every DIV enabled cycles and pulses wrap when it rolls over to 0.
// Every output comes straight from a flop.
module scan_decoder #(
    parameter int unsigned N       = 3,
    parameter int unsigned DIV     = 4,
    parameter bit          ACT_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              E,
    input  logic              mode,
    input  logic [N-1:0]      In,
    output logic [2**N-1:0]   Out,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int unsigned   W        = 2 ** N;
    localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);
    localparam logic [PW-1:0] PCNT_ONE = PW'(1);
    localparam logic [N-1:0]  IDX_MAX  = {N{1'b1}};
    localparam logic [N-1:0]  IDX_ONE  = N'(1);
    // Inactive pattern; all ones when the output is one-cold.
    localparam logic [W-1:0]  OUT_IDLE = {W{ACT_LOW}};

    logic [N-1:0]  idx_q, idx_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          wrap_q, wrap_d;
    // Out holds the registered enable implicitly: idle pattern when E was 0.
    logic [W-1:0]  out_q, out_d;

    // Next index, prescaler and wrap pulse from the current mode and enable.
    always_comb begin
        idx_d  = idx_q;
        pcnt_d = pcnt_q;
        wrap_d = 1'b0;
        if (E) begin
            if (!mode) begin
                // Direct decode discards any partial prescale count.
                idx_d  = In;
                pcnt_d = '0;
            end else if (pcnt_q == PCNT_MAX) begin
                pcnt_d = '0;
                idx_d  = idx_q + IDX_ONE;
                wrap_d = (idx_q == IDX_MAX);
            end else begin
                pcnt_d = pcnt_q + PCNT_ONE;
            end
        end
    end

    // Decode the next index so Out always matches idx once both are registered.
    always_comb begin
        out_d = OUT_IDLE;
        if (E) begin
            out_d[idx_d] = ~ACT_LOW;
        end
    end

    // State and output registers with asynchronous reset to the idle pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            pcnt_q <= '0;
            wrap_q <= 1'b0;
            out_q  <= OUT_IDLE;
        end else begin
            idx_q  <= idx_d;
            pcnt_q <= pcnt_d;
            wrap_q <= wrap_d;
            out_q  <= out_d;
        end
    end

    assign Out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: two N=3/DIV=4 instances (active-high and
// one-cold outputs) share stimulus and are checked against a scoreboard fed by
// a behavioural model; an N=1/DIV=1 instance covers the fastest scan corner.
module tb_scan_decoder;

    typedef struct packed {
        logic [7:0] out;
        logic [2:0] idx;
        logic       wrap;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en, mode;
    logic [2:0] sel;
    logic [7:0] out0, out1;
    logic [2:0] idx0, idx1;
    logic       wrap0, wrap1;
    logic       en2, mode2;
    logic [0:0] sel2;
    logic [1:0] out2;
    logic [0:0] idx2;
    logic       wrap2;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state for the N=3, DIV=4 instances.
    logic [2:0] m_idx;
    int         m_pcnt;
    logic       m_wrap;
    logic       m_en;
    exp_t       q[$];

    scan_decoder #(.N(3), .DIV(4), .ACT_LOW(1'b0)) u_hi (
        .clk (clk), .rst (rst), .E (en), .mode (mode), .In (sel),
        .Out (out0), .idx (idx0), .wrap (wrap0)
    );

    scan_decoder #(.N(3), .DIV(4), .ACT_LOW(1'b1)) u_lo (
        .clk (clk), .rst (rst), .E (en), .mode (mode), .In (sel),
        .Out (out1), .idx (idx1), .wrap (wrap1)
    );

    scan_decoder #(.N(1), .DIV(1), .ACT_LOW(1'b0)) u_min (
        .clk (clk), .rst (rst), .E (en2), .mode (mode2), .In (sel2),
        .Out (out2), .idx (idx2), .wrap (wrap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_idx  = 3'd0;
        m_pcnt = 0;
        m_wrap = 1'b0;
        m_en   = 1'b0;
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        m_wrap = 1'b0;
        if (en) begin
            if (!mode) begin
                m_idx  = sel;
                m_pcnt = 0;
            end else if (m_pcnt == 3) begin
                m_pcnt = 0;
                m_wrap = (m_idx == 3'd7);
                m_idx  = m_idx + 3'd1;
            end else begin
                m_pcnt = m_pcnt + 1;
            end
        end
        m_en = en;
    endtask

    // One clock: push the expectation, take the edge, pop and compare.
    task automatic tick(input string tag);
        exp_t x;
        model_step();
        x.out  = m_en ? (8'h01 << m_idx) : 8'h00;
        x.idx  = m_idx;
        x.wrap = m_wrap;
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        chk({tag, "_out"}, out0, x.out);
        chk({tag, "_idx"}, {5'b0, idx0}, {5'b0, x.idx});
        chk({tag, "_wrap"}, {7'b0, wrap0}, {7'b0, x.wrap});
        chk({tag, "_outlo"}, out1, ~x.out);
        chk({tag, "_wraplo"}, {7'b0, wrap1}, {7'b0, x.wrap});
    endtask

    initial begin
        int wraps;
        int wrap_at;

        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 3'd0;
        en2 = 1'b0; mode2 = 1'b0; sel2 = 1'b0;
        model_reset();
        #1;
        chk("rst_out", out0, 8'h00);
        chk("rst_idx", {5'b0, idx0}, 8'h00);
        chk("rst_wrap", {7'b0, wrap0}, 8'h00);
        chk("rst_outlo", out1, 8'hFF);
        chk("rst_out2", {6'b0, out2}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Direct decode: In 0..7, Out one clock later.
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            tick("dir");
            chk("dir_onehot", out0, 8'h01 << i);
        end

        // Disable freezes idx and blanks Out; re-enable loads In.
        en = 1'b0; sel = 3'b101;
        tick("dis");
        chk("dis_out", out0, 8'h00);
        chk("dis_idx", {5'b0, idx0}, 8'h07);
        tick("dis2");
        en = 1'b1;
        tick("ren");
        chk("ren_out", out0, 8'h20);

        // Full 32-clock scan from idx 0 with In scrambled (ignored).
        sel = 3'd0;
        tick("load0");
        mode = 1'b1;
        wraps = 0;
        wrap_at = 0;
        for (int k = 1; k <= 32; k++) begin
            sel = 3'($urandom);
            tick("scan");
            if (wrap0) begin
                wraps++;
                wrap_at = k;
            end
            if (k % 4 == 0) chk("scan_step", {5'b0, idx0}, 8'((k / 4) % 8));
        end
        chk("scan_wraps", 8'(wraps), 8'd1);
        chk("scan_wrap_at", 8'(wrap_at), 8'd32);
        chk("scan_wrap_out", out0, 8'h01);

        // Freeze at idx 5, pcnt 2 for 5 clocks, then resume.
        repeat (22) tick("scan2");
        chk("frz_start", {5'b0, idx0}, 8'h05);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick("frz");
            chk("frz_out", out0, 8'h00);
        end
        en = 1'b1;
        tick("res1");
        chk("res1_idx", {5'b0, idx0}, 8'h05);
        tick("res2");
        chk("res2_idx", {5'b0, idx0}, 8'h06);
        chk("res2_out", out0, 8'h40);

        // Run to the wrap cycle, then pulse reset between edges.
        repeat (8) tick("scan3");
        chk("pre_rst_wrap", {7'b0, wrap0}, 8'h01);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_out", out0, 8'h00);
        chk("arst_idx", {5'b0, idx0}, 8'h00);
        chk("arst_wrap", {7'b0, wrap0}, 8'h00);
        chk("arst_outlo", out1, 8'hFF);
        #1;
        rst = 1'b0;

        // First step after reset goes 0 -> 1 after DIV clocks.
        repeat (3) tick("post_rst");
        chk("post_rst_idx", {5'b0, idx0}, 8'h00);
        chk("post_rst_out", out0, 8'h01);
        tick("post_rst4");
        chk("post_rst_step", {5'b0, idx0}, 8'h01);

        // Partial prescale discarded by a mode-0 load; scan restarts from it.
        repeat (2) tick("partial");
        mode = 1'b0; sel = 3'd3;
        tick("m0");
        chk("m0_out", out0, 8'h08);
        mode = 1'b1;
        repeat (3) tick("m1");
        chk("m1_hold", {5'b0, idx0}, 8'h03);
        tick("m1s");
        chk("m1_step", {5'b0, idx0}, 8'h04);
        chk("m1_out", out0, 8'h10);

        // N=1, DIV=1: Out alternates every clock, wrap on each return to 0.
        en2 = 1'b1; mode2 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick("dual");
            chk("min_out", {6'b0, out2}, (k % 2 == 1) ? 8'h02 : 8'h01);
            chk("min_idx", {7'b0, idx2}, 8'(k % 2));
            chk("min_wrap", {7'b0, wrap2}, (k % 2 == 0) ? 8'h01 : 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter N, default 3: select width; output width is 2**N; legal range 1..6.
REQ-002 Parameter DIV, default 4: scan prescale in clock cycles per step; legal range 1..65535.
REQ-003 Parameter ACT_LOW, default 0: 1 inverts every bit of Out, including the reset and disabled patterns.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 E  input  1  enable; 0 forces Out inactive and freezes all state.
REQ-007 mode  input  1  0 = direct registered decode of In; 1 = auto-scan.
REQ-008 In  input  N  select index used in mode 0.
REQ-009 Out  output  2**N  registered one-hot output (one-cold when ACT_LOW=1).
REQ-010 idx  output  N  registered index currently driven on Out.
REQ-011 wrap  output  1  registered one-cycle pulse when the scan index wraps from 2**N-1 to 0.

Function
REQ-012 All outputs are registered; no combinational path from any input to any output.
REQ-013 Internal prescaler pcnt, width ceil(log2(DIV)) (minimum 1 bit), counts 0..DIV-1.
REQ-014 Out shall always equal onehot(idx) when the enabled flag is 1, and all-inactive when it is 0; the enabled flag is E registered, so Out follows E with one clock of latency.
REQ-015 E=0: idx, pcnt hold; wrap=0; Out all-inactive on the following edge.
REQ-016 Mode 0, E=1: idx <= In each cycle; pcnt <= 0; wrap=0; latency In -> Out is one clock.
REQ-017 Mode 1, E=1, pcnt < DIV-1: pcnt <= pcnt+1; idx holds; wrap=0.
REQ-018 Mode 1, E=1, pcnt = DIV-1: pcnt <= 0; idx <= idx+1 modulo 2**N; wrap <= 1 only when the old idx = 2**N-1.
REQ-019 wrap asserts in the same cycle that idx and Out show index 0; it lasts exactly one cycle.
REQ-020 DIV=1: idx advances every enabled mode-1 cycle; pcnt is held constant at 0.
REQ-021 Mode 0 -> 1 switch: the scan starts from the idx last loaded; pcnt starts from 0; the first step occurs DIV cycles after the switch edge.
REQ-022 Mode 1 -> 0 switch: idx <= In on the first mode-0 edge; any partial prescale count is discarded.
REQ-023 E deasserted mid-scan, then reasserted: the scan resumes with the frozen idx and pcnt, with no step lost and no step repeated.
REQ-024 In is ignored in mode 1; mode and In changes while E=0 take effect on the first enabled edge.
REQ-025 Out shall never have more than one active bit in any cycle, including across mode switches.

Reset
REQ-026 rst=1 asynchronously forces idx=0, pcnt=0, wrap=0, the enabled flag to 0, and Out all-inactive (all 0, or all 1 when ACT_LOW=1), independent of clk.
REQ-027 After rst deasserts, the first rising edge behaves per REQ-015..REQ-024 using the current inputs.
REQ-028 rst asserted mid-scan: the next enabled mode-1 step after release goes from idx 0 to 1, DIV cycles after release.

Verification
REQ-029 Direct decode (N=3): reset, E=1, mode=0, In stepped 0..7 one per clock -> Out = 8'h01, 02, 04 .. 80, each one clock after its In value; idx tracks In; wrap always 0.
REQ-030 Disable: E=0 with In=3'b101 -> Out=8'h00 on the next edge; idx holds its last value. E=1 again -> Out=8'h20 on the following edge.
REQ-031 Scan (N=3, DIV=4): mode=1 from idx 0 -> idx advances every 4 clocks through 0..7 and back to 0. When Out returns to 8'h01, wrap=1 for exactly one cycle. Full period = 32 clocks.
REQ-032 Freeze and resume: in mode 1, drop E for 5 clocks at pcnt=2, idx=5, then restore -> idx becomes 6 exactly 2 enabled cycles after E returns, and Out=8'h00 while frozen.
REQ-033 Async reset: pulse rst between clock edges mid-scan -> Out=0, idx=0 and wrap=0 immediately, before the next edge. Repeat with ACT_LOW=1 -> Out=8'hFF.
REQ-034 DIV=1 and N=1 corner: mode=1 -> Out alternates 2'b01/2'b10 every clock, and wrap is high on every cycle where idx=0 after the first step.
